// File: rtl/posit_add_arbiter.sv
// Round-robin front end for one shared, fixed-latency, non-stallable posit adder.
// Requester IDs ride a shadow tag line beside the adder; results queue in a credit-protected FIFO.
module posit_add_arbiter #(
  parameter int N          = 8,
  parameter int NREQ       = 4,
  parameter int LAT        = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic                add_start,
  output logic [N-1:0]        add_in1,
  output logic [N-1:0]        add_in2,
  input  logic [N-1:0]        add_result,
  input  logic                add_inf,
  input  logic                add_zero,
  input  logic                add_done,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [N-1:0]        res_data,
  output logic                res_inf,
  output logic                res_zero,
  output logic [IDW-1:0]      res_id,
  output logic                busy,
  output logic                err_seq
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int MW = $clog2(LAT + 1);
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [N-1:0]   data;
    logic           inf;
    logic           zero;
    logic [IDW-1:0] id;
  } entry_t;

  logic [IDW-1:0] last_q, grant, issue_id_q;
  logic           grant_vld, credit_ok, hs;
  logic [CW-1:0]  fifo_count_q, inflight_q;
  logic [CW:0]    occupancy;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  entry_t         mem [FIFO_DEPTH];
  entry_t         head;
  logic [LAT-1:0] tag_v_q;
  logic [IDW-1:0] tag_id_q [LAT];
  logic [MW-1:0]  mask_cnt_q;
  logic           masked, tap_v, push, pop, err_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Every result slot is reserved at grant time, so a full FIFO can never be pushed.
  assign occupancy = {1'b0, fifo_count_q} + {1'b0, inflight_q};
  assign credit_ok = occupancy < DEPTH_L;
  assign hs        = aresetn && credit_ok && grant_vld;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    int idx;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = int'(last_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_vld && req_valid[idx]) begin
        grant     = IDW'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[grant] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      add_start  <= 1'b0;
      add_in1    <= '0;
      add_in2    <= '0;
      issue_id_q <= '0;
      last_q     <= IDW'(NREQ - 1);
    end else begin
      add_start <= hs;
      add_in1   <= hs ? req_a[grant*N +: N] : '0;
      add_in2   <= hs ? req_b[grant*N +: N] : '0;
      if (hs) begin
        issue_id_q <= grant;
        last_q     <= grant;
      end
    end
  end

  // The adder has no reset, so its pulses are ignored until one full latency has passed.
  assign masked = mask_cnt_q < MW'(LAT);
  assign tap_v  = tag_v_q[LAT-1];
  assign push   = tap_v && add_done && !masked;
  assign pop    = res_valid && res_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tag_v_q    <= '0;
      for (int i = 0; i < LAT; i++) tag_id_q[i] <= '0;
      mask_cnt_q <= '0;
      err_q      <= 1'b0;
      inflight_q <= '0;
    end else begin
      tag_v_q     <= {tag_v_q[LAT-2:0], add_start};
      tag_id_q[0] <= issue_id_q;
      for (int i = 1; i < LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
      if (masked) mask_cnt_q <= mask_cnt_q + MW'(1);
      if (!masked && (tap_v != add_done)) err_q <= 1'b1;
      // A tap retires its credit whether or not the adder answered.
      unique case ({hs, tap_v})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + CW'(1);
        2'b01:   fifo_count_q <= fifo_count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; empty slots are never visible because the head is gated by res_valid.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr_q] <= '{data: add_result, inf: add_inf, zero: add_zero, id: tag_id_q[LAT-1]};
    end
  end

  assign res_valid = fifo_count_q != '0;
  assign head      = res_valid ? mem[rd_ptr_q] : '0;
  assign res_data  = head.data;
  assign res_inf   = head.inf;
  assign res_zero  = head.zero;
  assign res_id    = head.id;
  assign busy      = (inflight_q != '0) || res_valid;
  assign err_seq   = err_q;

endmodule

// File: tb/tb_posit_add_arbiter.sv
// Bench for posit_add_arbiter: a stand-in adder pipeline plus a queue-based model of issue order,
// credit and result latency, driven by directed sequences and random traffic.
module tb_posit_add_arbiter;

  localparam int N          = 8;
  localparam int NREQ       = 4;
  localparam int LAT        = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int IDW        = 2;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a = '0, req_b = '0;
  logic              add_start;
  logic [N-1:0]      add_in1, add_in2;
  logic [N-1:0]      add_result = '0;
  logic              add_inf = 1'b0, add_zero = 1'b0, add_done = 1'b0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [N-1:0]      res_data;
  logic              res_inf, res_zero;
  logic [IDW-1:0]    res_id;
  logic              busy, err_seq;

  always #5 aclk = ~aclk;

  posit_add_arbiter #(.N(N), .NREQ(NREQ), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH), .IDW(IDW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .add_start(add_start), .add_in1(add_in1), .add_in2(add_in2),
    .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_inf(res_inf), .res_zero(res_zero), .res_id(res_id),
    .busy(busy), .err_seq(err_seq)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stand-in adder: a fixed function of the operands with NaR and zero flags.
  // It maps 1.0+1.0 (0x40,0x40) to 0x42, 0+0 to zero and anything with NaR to NaR.
  function automatic logic [N+1:0] stub(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] r;
    logic         inf;
    inf = (a == 8'h80) || (b == 8'h80);
    r   = inf ? 8'h80 : a + (b >> 5);
    return {inf, (r == '0) && !inf, r};
  endfunction

  typedef struct {
    logic [N-1:0] data;
    logic         inf;
    logic         zero;
    int           id;
    int           t;
  } exp_t;

  exp_t            q[$];
  int              last_m = NREQ - 1;
  int              cyc = 0;
  int              dut_hs = 0;
  logic            exp_err = 1'b0;
  logic            prev_hs = 1'b0;
  logic [N-1:0]    prev_a = '0, prev_b = '0;

  logic [NREQ-1:0]   s_valid = '0;
  logic [NREQ*N-1:0] s_a = '0, s_b = '0;
  logic              s_ready = 1'b1, s_rstn = 1'b0, s_inj = 1'b0;

  bit           sh_v [LAT];
  bit [N-1:0]   sh_a [LAT];
  bit [N-1:0]   sh_b [LAT];

  task automatic rst_checks();
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_add_start", 32'(add_start), 32'(0));
    check("rst_add_in1",   32'(add_in1),   32'(0));
    check("rst_add_in2",   32'(add_in2),   32'(0));
    check("rst_res_valid", 32'(res_valid), 32'(0));
    check("rst_res_data",  32'(res_data),  32'(0));
    check("rst_res_inf",   32'(res_inf),   32'(0));
    check("rst_res_zero",  32'(res_zero),  32'(0));
    check("rst_res_id",    32'(res_id),    32'(0));
    check("rst_busy",      32'(busy),      32'(0));
    check("rst_err_seq",   32'(err_seq),   32'(0));
  endtask

  task automatic observe();
    logic [NREQ-1:0] exp_ready;
    logic [N+1:0]    s;
    exp_t            e;
    int              gsel;
    int              g;
    if ((req_valid & req_ready) != '0) dut_hs++;
    if (!aresetn) begin
      rst_checks();
      q.delete();
      last_m  = NREQ - 1;
      prev_hs = 1'b0;
      prev_a  = '0;
      prev_b  = '0;
      return;
    end
    check("add_start", 32'(add_start), 32'(prev_hs));
    check("add_in1",   32'(add_in1),   32'(prev_a));
    check("add_in2",   32'(add_in2),   32'(prev_b));
    check("busy",      32'(busy),      32'(q.size() != 0));
    check("err_seq",   32'(err_seq),   32'(exp_err));
    if (q.size() != 0) check("res_valid", 32'(res_valid), 32'((q[0].t + LAT + 2) <= cyc));
    else               check("res_valid", 32'(res_valid), 32'(0));

    exp_ready = '0;
    gsel      = -1;
    if (q.size() < FIFO_DEPTH) begin
      for (int off = 1; off <= NREQ; off++) begin
        g = (last_m + off) % NREQ;
        if (gsel < 0 && req_valid[g]) gsel = g;
      end
    end
    if (gsel >= 0) exp_ready[gsel] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));

    if (res_valid && res_ready) begin
      if (q.size() == 0) check("res_extra", 32'(res_valid), 32'(0));
      else begin
        check("res_data", 32'(res_data), 32'(q[0].data));
        check("res_inf",  32'(res_inf),  32'(q[0].inf));
        check("res_zero", 32'(res_zero), 32'(q[0].zero));
        check("res_id",   32'(res_id),   32'(q[0].id));
        void'(q.pop_front());
      end
    end

    prev_hs = 1'b0;
    prev_a  = '0;
    prev_b  = '0;
    if (gsel >= 0) begin
      prev_hs = 1'b1;
      prev_a  = req_a[gsel*N +: N];
      prev_b  = req_b[gsel*N +: N];
      s       = stub(prev_a, prev_b);
      e.data  = s[N-1:0];
      e.inf   = s[N+1];
      e.zero  = s[N];
      e.id    = gsel;
      e.t     = cyc;
      q.push_back(e);
      last_m  = gsel;
    end
  endtask

  task automatic cycle();
    logic [N+1:0] s;
    @(posedge aclk);
    #1;
    aresetn   = s_rstn;
    req_valid = s_valid;
    req_a     = s_a;
    req_b     = s_b;
    res_ready = s_ready;
    if (s_inj) begin
      add_done   = 1'b1;
      add_result = N'($urandom);
      add_inf    = 1'b0;
      add_zero   = 1'b0;
    end else begin
      s          = stub(sh_a[LAT-1], sh_b[LAT-1]);
      add_done   = sh_v[LAT-1];
      add_result = s[N-1:0];
      add_inf    = s[N+1];
      add_zero   = s[N];
    end
    s_inj = 1'b0;
    @(negedge aclk);
    observe();
    for (int k = LAT - 1; k > 0; k--) begin
      sh_v[k] = sh_v[k-1];
      sh_a[k] = sh_a[k-1];
      sh_b[k] = sh_b[k-1];
    end
    sh_v[0] = add_start;
    sh_a[0] = add_in1;
    sh_b[0] = add_in2;
    cyc++;
  endtask

  task automatic do_reset(input int hold);
    #2;
    s_valid   = '1;
    req_valid = '1;
    aresetn   = 1'b0;
    s_rstn    = 1'b0;
    #1;
    rst_checks();
    q.delete();
    last_m  = NREQ - 1;
    prev_hs = 1'b0;
    prev_a  = '0;
    prev_b  = '0;
    exp_err = 1'b0;
    repeat (hold) cycle();
    s_valid = '0;
    s_rstn  = 1'b1;
  endtask

  task automatic set_req(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
    s_valid          = '0;
    s_valid[id]      = 1'b1;
    s_a[id*N +: N]   = a;
    s_b[id*N +: N]   = b;
  endtask

  int hs_mark;

  initial begin
    for (int k = 0; k < LAT; k++) begin
      sh_v[k] = 1'b0;
      sh_a[k] = '0;
      sh_b[k] = '0;
    end
    repeat (3) cycle();
    s_rstn = 1'b1;
    cycle();

    // Single request from requester 2: 1.0 + 1.0
    set_req(2, 8'h40, 8'h40);
    cycle();
    s_valid = '0;
    repeat (LAT + 4) cycle();

    // Round-robin with every requester asserting
    s_valid = '1;
    repeat (12) begin
      s_a = $urandom;
      s_b = $urandom;
      cycle();
    end
    s_valid = '0;
    repeat (LAT + 6) cycle();

    // Zero and NaR operands
    set_req(0, 8'h00, 8'h00);
    cycle();
    set_req(1, 8'h80, 8'h40);
    cycle();
    s_valid = '0;
    repeat (LAT + 4) cycle();

    // Backpressure: credit must stop issue at exactly the FIFO depth
    s_ready = 1'b0;
    s_valid = '1;
    hs_mark = dut_hs;
    repeat (30) begin
      s_a = $urandom;
      s_b = $urandom;
      cycle();
    end
    check("bp_handshakes", 32'(dut_hs - hs_mark), 32'(FIFO_DEPTH));
    check("bp_ready_low", 32'(req_ready), 32'(0));
    s_ready = 1'b1;
    repeat (10) cycle();
    s_valid = '0;
    repeat (LAT + FIFO_DEPTH + 6) cycle();

    // Reset with three operations in flight, then stale adder pulses
    set_req(1, 8'h40, 8'h20);
    repeat (3) cycle();
    s_valid = '0;
    repeat (4) cycle();
    do_reset(2);
    repeat (3) cycle();
    s_inj = 1'b1;
    repeat (LAT + 2) cycle();

    // Spurious done once masking has expired
    s_inj = 1'b1;
    cycle();
    exp_err = 1'b1;
    repeat (6) cycle();
    check("err_sticky", 32'(err_seq), 32'(1));

    // Random traffic from a clean reset
    do_reset(1);
    repeat (300) begin
      s_valid = NREQ'($urandom);
      s_a     = $urandom;
      s_b     = $urandom;
      s_ready = ($urandom % 4) != 0;
      cycle();
    end
    s_valid = '0;
    s_ready = 1'b1;
    repeat (LAT + FIFO_DEPTH + 6) cycle();
    check("drained_busy", 32'(busy), 32'(0));
    check("drained_model", 32'(q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
